// File: rtl/clock_set_controller.sv
// Sequencing controller for the seconds/minutes/hours counter chain of a 12-hour clock.
// Turns the 1 Hz tick into count enables in RUN; handles hour/minute setting with auto-repeat and blanking.
//
// state   | meaning
// --------+----------------------------------------------------------
// RUN     | normal timekeeping, tick drives the counter chain
// SET_HR  | seconds frozen, btn_inc steps hours, hours digits blink
// SET_MIN | seconds frozen, btn_inc steps minutes, minutes digits blink
module clock_set_controller #(
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int BLINK_HALF    = 25000000,
    parameter int TIMEOUT_S     = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_max,
    input  logic       min_max,
    output logic       sec_ena,
    output logic       min_ena,
    output logic       hr_ena,
    output logic       sec_clr,
    output logic       hr_blank,
    output logic       min_blank,
    output logic [1:0] mode
);

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(REP_MAX + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);
    localparam logic [BW-1:0] BLINK_LOAD  = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LOAD     = TW'(TIMEOUT_S - 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } state_t;

    state_t state, state_nxt;

    logic mode_q, mode_qq, inc_q, inc_qq;
    logic mode_press, inc_press;

    logic [RW-1:0] rep_cnt, rep_cnt_nxt;
    logic          rep_act, rep_act_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;
    logic [TW-1:0] to_cnt, to_cnt_nxt;

    logic in_set, step, timeout;
    logic sec_ena_nxt, min_ena_nxt, hr_ena_nxt, sec_clr_nxt;
    logic hr_blank_nxt, min_blank_nxt;

    assign mode_press = mode_q & ~mode_qq;
    assign inc_press  = inc_q & ~inc_qq;
    assign mode       = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            mode_q      <= 1'b0;
            mode_qq     <= 1'b0;
            inc_q       <= 1'b0;
            inc_qq      <= 1'b0;
            rep_cnt     <= '0;
            rep_act     <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            to_cnt      <= '0;
            sec_ena     <= 1'b0;
            min_ena     <= 1'b0;
            hr_ena      <= 1'b0;
            sec_clr     <= 1'b0;
            hr_blank    <= 1'b0;
            min_blank   <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode_q      <= btn_mode;
            mode_qq     <= mode_q;
            inc_q       <= btn_inc;
            inc_qq      <= inc_q;
            rep_cnt     <= rep_cnt_nxt;
            rep_act     <= rep_act_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            to_cnt      <= to_cnt_nxt;
            sec_ena     <= sec_ena_nxt;
            min_ena     <= min_ena_nxt;
            hr_ena      <= hr_ena_nxt;
            sec_clr     <= sec_clr_nxt;
            hr_blank    <= hr_blank_nxt;
            min_blank   <= min_blank_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        in_set          = (state != RUN);
        step            = 1'b0;
        timeout         = 1'b0;
        rep_cnt_nxt     = rep_cnt;
        rep_act_nxt     = rep_act & inc_q;
        to_cnt_nxt      = to_cnt;
        blink_cnt_nxt   = blink_cnt;
        blink_phase_nxt = blink_phase;
        sec_ena_nxt     = 1'b0;
        min_ena_nxt     = 1'b0;
        hr_ena_nxt      = 1'b0;
        sec_clr_nxt     = 1'b0;
        hr_blank_nxt    = 1'b0;
        min_blank_nxt   = 1'b0;

        // A mode press takes priority over inc and kills any repeat in progress.
        if (in_set && !mode_press) begin
            if (inc_press) begin
                step        = 1'b1;
                rep_act_nxt = 1'b1;
                rep_cnt_nxt = DELAY_LOAD;
            end else if (rep_act && inc_q) begin
                if (rep_cnt == '0) begin
                    step        = 1'b1;
                    rep_cnt_nxt = PERIOD_LOAD;
                end else begin
                    rep_cnt_nxt = rep_cnt - RW'(1);
                end
            end
        end else begin
            rep_act_nxt = 1'b0;
            rep_cnt_nxt = '0;
        end

        // Timeout is evaluated independently of mode press so both can coincide in SET_HR.
        timeout = in_set && tick && (to_cnt == '0) && !step;
        if (!in_set || step || mode_press || timeout) begin
            to_cnt_nxt = TO_LOAD;
        end else if (tick) begin
            to_cnt_nxt = to_cnt - TW'(1);
        end

        case (state)
            RUN: begin
                if (mode_press) state_nxt = SET_HR;
            end
            SET_HR: begin
                if (timeout)         state_nxt = RUN;
                else if (mode_press) state_nxt = SET_MIN;
            end
            SET_MIN: begin
                if (timeout || mode_press) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase

        case (state)
            RUN: begin
                sec_ena_nxt = tick;
                min_ena_nxt = tick & sec_max;
                hr_ena_nxt  = tick & sec_max & min_max;
            end
            SET_HR:  hr_ena_nxt  = step;
            SET_MIN: min_ena_nxt = step;
            default: ;
        endcase

        sec_clr_nxt = in_set && (state_nxt == RUN);

        // Restart the blink on every mode change so the digits show immediately.
        if (state_nxt != state) begin
            blink_cnt_nxt   = BLINK_LOAD;
            blink_phase_nxt = 1'b0;
        end else if (blink_cnt == '0) begin
            blink_cnt_nxt   = BLINK_LOAD;
            blink_phase_nxt = ~blink_phase;
        end else begin
            blink_cnt_nxt = blink_cnt - BW'(1);
        end

        hr_blank_nxt  = (state_nxt == SET_HR) & blink_phase_nxt;
        min_blank_nxt = (state_nxt == SET_MIN) & blink_phase_nxt;
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with short timing parameters.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_clock_set_controller;

    localparam int REPEAT_DELAY  = 8;
    localparam int REPEAT_PERIOD = 4;
    localparam int BLINK_HALF    = 3;
    localparam int TIMEOUT_S     = 3;

    logic       clk = 1'b0;
    logic       reset, tick, btn_mode, btn_inc, sec_max, min_max;
    logic       sec_ena, min_ena, hr_ena, sec_clr, hr_blank, min_blank;
    logic [1:0] mode;

    int n_checks = 0;
    int n_fail   = 0;

    clock_set_controller #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD),
        .BLINK_HALF   (BLINK_HALF),
        .TIMEOUT_S    (TIMEOUT_S)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .sec_max  (sec_max),
        .min_max  (min_max),
        .sec_ena  (sec_ena),
        .min_ena  (min_ena),
        .hr_ena   (hr_ena),
        .sec_clr  (sec_clr),
        .hr_blank (hr_blank),
        .min_blank(min_blank),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tic;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ena(input string tag, input logic s, input logic m, input logic h);
        chk({tag, ".sec_ena"}, sec_ena, s);
        chk({tag, ".min_ena"}, min_ena, m);
        chk({tag, ".hr_ena"},  hr_ena,  h);
    endtask

    task automatic chk_idle(input string tag);
        chk_ena(tag, 1'b0, 1'b0, 1'b0);
        chk({tag, ".sec_clr"},   sec_clr,   1'b0);
        chk({tag, ".hr_blank"},  hr_blank,  1'b0);
        chk({tag, ".min_blank"}, min_blank, 1'b0);
        chk({tag, ".mode"},      mode,      2'b00);
    endtask

    // Single-sample press; returns two cycles later when the new mode is visible.
    task automatic mode_press;
        btn_mode = 1'b1;
        tic;
        btn_mode = 1'b0;
        tic;
    endtask

    // Hold btn_inc for 21 samples; steps expected at relative cycles 0,8,12,16,20.
    task automatic repeat_run(input string tag, input bit on_min);
        logic exp_step;
        btn_inc = 1'b1;
        for (int c = 1; c <= 35; c++) begin
            tic;
            if (c == 21) btn_inc = 1'b0;
            exp_step = (c == 2) || (c == 10) || (c == 14) || (c == 18) || (c == 22);
            if (on_min) chk_ena($sformatf("%s.c%0d", tag, c), 1'b0, exp_step, 1'b0);
            else        chk_ena($sformatf("%s.c%0d", tag, c), 1'b0, 1'b0, exp_step);
        end
    endtask

    initial begin
        logic [6:0] blink_exp;
        reset = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
        sec_max = 1'b0; min_max = 1'b0;
        tic; tic; tic;
        chk_idle("reset");
        reset = 1'b0;
        tic;
        chk_idle("post_reset");

        // RUN carry chain
        tick = 1'b1; sec_max = 1'b1; min_max = 1'b1;
        tic;
        tick = 1'b0;
        chk_ena("carry_all", 1'b1, 1'b1, 1'b1);
        tic;
        chk_ena("carry_all_next", 1'b0, 1'b0, 1'b0);
        tick = 1'b1; sec_max = 1'b0;
        tic;
        tick = 1'b0;
        chk_ena("carry_sec_only", 1'b1, 1'b0, 1'b0);
        tick = 1'b1; sec_max = 1'b1; min_max = 1'b0;
        tic;
        tick = 1'b0; sec_max = 1'b0;
        chk_ena("carry_sec_min", 1'b1, 1'b1, 1'b0);
        tic;

        // inc ignored in RUN
        btn_inc = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tic;
            chk_ena("run_inc_ignored", 1'b0, 1'b0, 1'b0);
        end
        btn_inc = 1'b0;
        tic;

        // Mode cycling
        mode_press;
        chk("cyc1.mode", mode, 2'b01);
        chk("cyc1.sec_clr", sec_clr, 1'b0);
        tick = 1'b1; tic; tick = 1'b0;
        chk_ena("cyc1.tick", 1'b0, 1'b0, 1'b0);
        mode_press;
        chk("cyc2.mode", mode, 2'b10);
        chk("cyc2.sec_clr", sec_clr, 1'b0);
        tick = 1'b1; tic; tick = 1'b0;
        chk_ena("cyc2.tick", 1'b0, 1'b0, 1'b0);
        mode_press;
        chk("cyc3.mode", mode, 2'b00);
        chk("cyc3.sec_clr", sec_clr, 1'b1);
        tic;
        chk("cyc3.sec_clr_end", sec_clr, 1'b0);

        // Auto-repeat in SET_HR
        mode_press;
        chk("rep_hr.mode", mode, 2'b01);
        repeat_run("rep_hr", 1'b0);
        chk("rep_hr.mode_end", mode, 2'b01);

        // Blink on entering SET_MIN
        mode_press;
        chk("blink.mode", mode, 2'b10);
        blink_exp = 7'b0111000;   // bit c = expected min_blank at relative cycle c
        chk("blink.c0", min_blank, blink_exp[0]);
        chk("blink.hr0", hr_blank, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tic;
            chk($sformatf("blink.c%0d", c), min_blank, blink_exp[c]);
            chk($sformatf("blink.hr%0d", c), hr_blank, 1'b0);
        end

        // Auto-repeat in SET_MIN never reaches hours
        sec_max = 1'b1; min_max = 1'b1;
        repeat_run("rep_min", 1'b1);
        mode_press;
        chk("min_to_run.mode", mode, 2'b00);
        chk("min_to_run.sec_clr", sec_clr, 1'b1);
        chk("min_to_run.min_blank", min_blank, 1'b0);
        chk("min_to_run.hr_blank", hr_blank, 1'b0);
        sec_max = 1'b0; min_max = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tic;
            chk("run_blank.min", min_blank, 1'b0);
            chk("run_blank.hr", hr_blank, 1'b0);
        end

        // Timeout
        mode_press;
        chk("to.mode", mode, 2'b01);
        for (int t = 1; t <= 3; t++) begin
            tick = 1'b1; tic; tick = 1'b0;
            if (t < 3) chk($sformatf("to.tick%0d", t), mode, 2'b01);
        end
        chk("to.mode_run", mode, 2'b00);
        chk("to.sec_clr", sec_clr, 1'b1);
        tic;
        chk("to.sec_clr_end", sec_clr, 1'b0);

        // Timeout cancelled by an inc press on the third tick
        mode_press;
        tick = 1'b1; tic; tick = 1'b0;
        tick = 1'b1; tic; tick = 1'b0;
        chk("tocan.mode_pre", mode, 2'b01);
        btn_inc = 1'b1;
        tic;
        tick = 1'b1;
        tic;
        tick = 1'b0; btn_inc = 1'b0;
        chk("tocan.mode", mode, 2'b01);
        chk("tocan.hr_ena", hr_ena, 1'b1);
        chk("tocan.sec_clr", sec_clr, 1'b0);
        tic;
        chk("tocan.mode_hold", mode, 2'b01);
        tic;

        // Mode and inc pressed together in SET_HR
        btn_mode = 1'b1; btn_inc = 1'b1;
        tic;
        btn_mode = 1'b0; btn_inc = 1'b0;
        tic;
        chk("coll.mode", mode, 2'b10);
        chk_ena("coll", 1'b0, 1'b0, 1'b0);
        tic;
        chk_ena("coll_next", 1'b0, 1'b0, 1'b0);
        mode_press;
        chk("coll_exit.mode", mode, 2'b00);
        chk("coll_exit.sec_clr", sec_clr, 1'b1);

        // Reset while auto-repeat is running
        mode_press;
        chk("rst.mode_pre", mode, 2'b01);
        btn_inc = 1'b1;
        repeat (12) tic;
        reset = 1'b1;
        tic;
        chk_idle("rst.during0");
        tic;
        chk_idle("rst.during1");
        reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tic;
            chk_idle($sformatf("rst.after%0d", c));
        end
        btn_inc = 1'b0;
        tic;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_set_controller.md
# clock_set_controller

Sequencing controller for the 12-hour clock's seconds, minutes and hours counter chain. In RUN mode it turns the 1 Hz tick and counter terminal-count flags into per-stage count enables. In SET modes it freezes seconds, steps hours or minutes from the increment button (with auto-repeat), and drives blanking for the digit pair being set. It sits between the debounced button inputs / tick generator and the counter chain.

## Interface
- REPEAT_DELAY, 50000000: clk cycles btn_inc must be held before auto-repeat starts
- REPEAT_PERIOD, 10000000: clk cycles between auto-repeat steps
- BLINK_HALF, 25000000: clk cycles per blink half-period
- TIMEOUT_S, 30: tick pulses without button activity before a SET mode falls back to RUN

- clk  in  1  system clock; same domain as counter chain
- reset  in  1  synchronous, active-high
- tick  in  1  one-cycle 1 Hz strobe
- btn_mode  in  1  debounced level, 1 = pressed
- btn_inc  in  1  debounced level, 1 = pressed
- sec_max  in  1  seconds counter == 59
- min_max  in  1  minutes counter == 59
- sec_ena  out  1  one-cycle seconds count enable
- min_ena  out  1  one-cycle minutes count enable
- hr_ena  out  1  one-cycle hours count enable
- sec_clr  out  1  one-cycle synchronous clear of seconds counter
- hr_blank  out  1  blank hours digits
- min_blank  out  1  blank minutes digits
- mode  out  2  00 RUN, 01 SET_HR, 10 SET_MIN

## Operation
- Edge detect: each button is registered once. A press is a 0->1 transition between the previous and current sampled value.
- FSM states and transitions:
  - RUN: mode press -> SET_HR.
  - SET_HR: mode press -> SET_MIN.
  - SET_MIN: mode press -> RUN.
  - Timeout in either SET state -> RUN.
- sec_clr pulses for 1 cycle on every SET_MIN->RUN or timeout->RUN transition. It never pulses on RUN->SET_HR.
- RUN enables:
  - sec_ena = tick.
  - min_ena = tick & sec_max.
  - hr_ena = tick & sec_max & min_max.
  - btn_inc is ignored in RUN.
- SET_HR / SET_MIN:
  - tick does not produce sec_ena, min_ena or hr_ena.
  - An inc press gives one step: hr_ena in SET_HR, min_ena in SET_MIN.
  - If btn_inc stays high for REPEAT_DELAY cycles after the press, one step is issued. Further steps follow every REPEAT_PERIOD cycles while btn_inc is held. Release stops repeat immediately.
  - Minutes stepping never produces hr_ena, even when min_max = 1.
- Blink: a free-running phase counter toggles blink_phase every BLINK_HALF cycles. Blanking is active only in SET modes:
  - hr_blank = (mode == SET_HR) & blink_phase.
  - min_blank = (mode == SET_MIN) & blink_phase.
  - On any mode change the phase counter reloads and blink_phase = 0, so the digits are visible immediately.
- Timeout: an inactivity counter counts tick pulses in SET modes.
  - Any press or repeat step clears it.
  - Reaching TIMEOUT_S forces RUN.
  - It is cleared on entering RUN.
- Simultaneous events:
  - A mode press and an inc press in the same cycle: the mode press wins and inc is ignored. The repeat counter is also cleared.
  - Timeout and inc press in the same cycle: the press wins and the timeout is cancelled.
  - Timeout and mode press in the same cycle in SET_HR: the result is RUN, with sec_clr.
- Counter widths: each internal counter is sized to hold its parameter, with no wrap before terminal count.
- Reset: the FSM goes to RUN and all counters and edge registers clear. The edge registers clear to 0, so a button held through reset registers as a press on the first cycle after reset.

## Timing
- All outputs are registered and are 0 during and after reset until driven. Reset values: mode = 00, blink_phase = 0.
- tick at cycle N -> sec_ena, min_ena, hr_ena at cycle N+1. sec_max and min_max are sampled at cycle N.
- Button input 0->1 sampled at cycle N -> press detected at N+1 -> step enable or mode change visible at N+2.
- First repeat step comes REPEAT_DELAY cycles after the initial step. Subsequent steps are REPEAT_PERIOD cycles apart.
- sec_clr is asserted in the same cycle mode becomes 00.
- Enables are never asserted for more than one consecutive cycle per event. The sole exception is REPEAT_PERIOD = 1, where steps occur back-to-back.

## Test plan
Bench parameters: REPEAT_DELAY=8, REPEAT_PERIOD=4, BLINK_HALF=3, TIMEOUT_S=3.
- RUN carry chain: tick with sec_max=1, min_max=1 -> sec_ena, min_ena, hr_ena all 1 for exactly one cycle, one cycle after tick. With sec_max=0, only sec_ena is asserted.
- Mode cycling: three mode presses -> mode 01, 10, 00. sec_clr is a 1-cycle pulse only on the 10->00 transition. Ticks while mode != 00 produce no enables.
- Auto-repeat in SET_HR: hold btn_inc for 20 cycles -> hr_ena pulses at relative cycles 0, 8, 12, 16, 20. Release -> no further pulses. Same hold in SET_MIN with min_max=1 -> min_ena only, hr_ena never asserted.
- Blink: in SET_MIN, min_blank follows the pattern 0,0,0,1,1,1,... and hr_blank stays 0. On switching to RUN, both are 0.
- Timeout: enter SET_HR and issue 3 ticks with no buttons -> mode=00 with a sec_clr pulse. An inc press on the third tick cycle keeps mode=01.
- Collisions and reset: mode and inc pressed in the same cycle in SET_HR -> mode=10, no hr_ena. Assert reset mid-repeat -> all outputs 0, mode=00, and no enable pulses after reset is released until a new press.
